hv_sync_tracker: RTL and testbench

Receive-side counterpart of the PPU H/V counters: recovers dot position and scanline from the HSYNC/VSYNC pulses emitted by the PPU video output, measures every line length and maintains a lock state. Sits in the video capture/monitor path on the PPU pixel clock. Its H/V outputs must match the PPU's internal counters once locked, so the bench and downstream scalers can use them.

---
 rtl/hv_sync_pkg.sv | 16 +
 rtl/hv_sync_tracker_sync_edge.sv | 26 ++
 rtl/hv_sync_tracker.sv | 131 +++++++++++++
 tb/tb_hv_sync_tracker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hv_sync_pkg.sv
// Shared constants and FSM state type for the HSYNC/VSYNC tracker.
package hv_sync_pkg;

  localparam int unsigned CNT_W         = 9;
  localparam int unsigned DOTS_PER_LINE = 341;
  localparam int unsigned SHORT_DOTS    = 340;
  localparam int unsigned H_SAT         = 511;
  localparam int unsigned V_SAT         = 511;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_e;

endpackage

// File: rtl/hv_sync_tracker_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse on the second stage.
module sync_edge
  import hv_sync_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic q;
  logic qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= 1'b0;
      qq <= 1'b0;
    end else begin
      q  <= d;
      qq <= q;
    end
  end

  assign rise_c = q & ~qq;

endmodule

// File: rtl/hv_sync_tracker.sv
// Recovers PPU dot/scanline counters from HSYNC/VSYNC and tracks line-length lock.
// Optional feature macro: PPU_HV_SYNC_ODD_SKIP_EN (accept 340-dot odd-frame lines).
module hv_sync_tracker
  import hv_sync_pkg::*;
#(
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic                 PCLK,
  input  logic                 RES,
  input  logic                 HSYNC,
  input  logic                 VSYNC,
  output logic [CNT_W-1:0]     H_out,
  output logic [CNT_W-1:0]     V_out,
  output logic [CNT_W-1:0]     LINE_LEN,
  output logic                 LOCKED,
  output logic                 SHORT_LINE,
  output logic                 SYNC_ERR
);

  localparam int unsigned GOOD_W = $clog2(LOCK_LINES + 1);

  logic              hrise_c;
  logic              vrise_c;
  logic              vpend;
  logic [CNT_W-1:0]  len_c;
  logic              len_ok_c;
  logic              short_c;
  logic [GOOD_W-1:0] good_cnt;
  sync_state_e       state;

  sync_edge u_hsync (
    .clk    (PCLK),
    .rst    (RES),
    .d      (HSYNC),
    .rise_c (hrise_c)
  );

  sync_edge u_vsync (
    .clk    (PCLK),
    .rst    (RES),
    .d      (VSYNC),
    .rise_c (vrise_c)
  );

  // Length of the line closing on this hrise; a saturated counter reports 511.
  assign len_c = (H_out == CNT_W'(H_SAT)) ? CNT_W'(H_SAT) : H_out + CNT_W'(1);

`ifdef PPU_HV_SYNC_ODD_SKIP_EN
  assign short_c  = (len_c == CNT_W'(SHORT_DOTS));
  assign len_ok_c = (len_c == CNT_W'(DOTS_PER_LINE)) | short_c;
`else
  assign short_c  = 1'b0;
  assign len_ok_c = (len_c == CNT_W'(DOTS_PER_LINE));
`endif

  // Dot/line counters run freely in every lock state.
  always_ff @(posedge PCLK) begin
    if (RES) begin
      H_out      <= '0;
      V_out      <= '0;
      LINE_LEN   <= '0;
      vpend      <= 1'b0;
      SHORT_LINE <= 1'b0;
    end else begin
      SHORT_LINE <= hrise_c & short_c;
      if (hrise_c) begin
        H_out    <= '0;
        LINE_LEN <= len_c;
      end else if (H_out != CNT_W'(H_SAT)) begin
        H_out <= H_out + CNT_W'(1);
      end
      if (hrise_c) begin
        vpend <= 1'b0;
        if (vpend | vrise_c) begin
          V_out <= '0;
        end else if (V_out != CNT_W'(V_SAT)) begin
          V_out <= V_out + CNT_W'(1);
        end
      end else if (vrise_c) begin
        vpend <= 1'b1;
      end
    end
  end

  // Lock FSM: SEARCH waits for any edge, ACQUIRE counts good lines, LOCKED watches for loss.
  always_ff @(posedge PCLK) begin
    if (RES) begin
      state    <= ST_SEARCH;
      good_cnt <= '0;
      LOCKED   <= 1'b0;
      SYNC_ERR <= 1'b0;
    end else begin
      SYNC_ERR <= 1'b0;
      case (state)
        ST_SEARCH: begin
          if (hrise_c) begin
            state    <= ST_ACQUIRE;
            good_cnt <= '0;
          end
        end
        ST_ACQUIRE: begin
          if (hrise_c) begin
            if (!len_ok_c) begin
              good_cnt <= '0;
            end else if (good_cnt == GOOD_W'(LOCK_LINES - 1)) begin
              state    <= ST_LOCKED;
              LOCKED   <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_cnt + GOOD_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          if ((hrise_c && !len_ok_c) ||
              (!hrise_c && H_out == CNT_W'(H_SAT - 1))) begin
            state    <= ST_SEARCH;
            LOCKED   <= 1'b0;
            SYNC_ERR <= 1'b1;
          end
        end
        default: begin
          state    <= ST_SEARCH;
          LOCKED   <= 1'b0;
          good_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_sync_tracker.sv
// Table-driven scoreboard bench for hv_sync_tracker; expectations follow PPU_HV_SYNC_ODD_SKIP_EN.
module tb_hv_sync_tracker;

  logic       PCLK;
  logic       RES;
  logic       HSYNC;
  logic       VSYNC;
  logic [8:0] H_out;
  logic [8:0] V_out;
  logic [8:0] LINE_LEN;
  logic       LOCKED;
  logic       SHORT_LINE;
  logic       SYNC_ERR;

  typedef struct {
    int         due;
    string      name;
    logic [8:0] h;
    logic [8:0] v;
    logic [8:0] len;
    logic       locked;
    logic       short_l;
    logic       err;
    bit         chk_v;
    bit         chk_len;
  } exp_t;

  typedef struct {
    int         gap;
    int         width;
    int         vat;
    bit         chk_len;
    logic [8:0] len;
    logic       locked;
    logic       short_l;
    logic       err;
  } vec_t;

  exp_t       sbq[$];
  vec_t       tbl[19];
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_err    = 0;
  logic [8:0] vexp     = 9'd0;
  bit         vpend_m  = 1'b0;

  hv_sync_tracker #(.LOCK_LINES(4)) dut (
    .PCLK       (PCLK),
    .RES        (RES),
    .HSYNC      (HSYNC),
    .VSYNC      (VSYNC),
    .H_out      (H_out),
    .V_out      (V_out),
    .LINE_LEN   (LINE_LEN),
    .LOCKED     (LOCKED),
    .SHORT_LINE (SHORT_LINE),
    .SYNC_ERR   (SYNC_ERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  function automatic exp_t mk_exp(input int due, input string name,
                                  input logic [8:0] h, input logic [8:0] v,
                                  input logic [8:0] len, input logic locked,
                                  input logic short_l, input logic err,
                                  input bit chk_v, input bit chk_len);
    exp_t e;
    e.due = due; e.name = name; e.h = h; e.v = v; e.len = len;
    e.locked = locked; e.short_l = short_l; e.err = err;
    e.chk_v = chk_v; e.chk_len = chk_len;
    return e;
  endfunction

  function automatic vec_t mk_vec(input int gap, input int width, input int vat,
                                  input bit chk_len, input logic [8:0] len,
                                  input logic locked, input logic short_l,
                                  input logic err);
    vec_t p;
    p.gap = gap; p.width = width; p.vat = vat; p.chk_len = chk_len;
    p.len = len; p.locked = locked; p.short_l = short_l; p.err = err;
    return p;
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  task automatic check(input exp_t e);
    bit ok;
    n_checks = n_checks + 1;
    ok = (e.due == cyc) && (H_out === e.h) && (LOCKED === e.locked) &&
         (SHORT_LINE === e.short_l) && (SYNC_ERR === e.err) &&
         (!e.chk_v || V_out === e.v) && (!e.chk_len || LINE_LEN === e.len);
    if (!ok) begin
      n_err = n_err + 1;
      $display("FAIL %s cyc=%0d due=%0d: got h=%0d v=%0d len=%0d lk=%0b sh=%0b er=%0b, want h=%0d v=%0d len=%0d lk=%0b sh=%0b er=%0b",
               e.name, cyc, e.due, H_out, V_out, LINE_LEN, LOCKED, SHORT_LINE, SYNC_ERR,
               e.h, e.v, e.len, e.locked, e.short_l, e.err);
    end
  endtask

  // Pops every expectation due on this edge and compares post-edge outputs.
  always @(posedge PCLK) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check(e);
    end
  end

  // One HSYNC pulse opening a line of p.gap dots; expectations queued for its hrise.
  task automatic pulse(input vec_t p, input bit hseq, input string name);
    int c0;
    int hs[4];
    hs = '{1, 100, 200, 340};
    c0 = cyc;
    if (vpend_m || p.vat == 0) begin
      vexp    = 9'd0;
      vpend_m = 1'b0;
    end else if (vexp != 9'd511) begin
      vexp = vexp + 9'd1;
    end
    sbq.push_back(mk_exp(c0 + 2, name, 9'd0, vexp, p.len, p.locked, p.short_l, p.err,
                         1'b1, p.chk_len));
    if (hseq) begin
      for (int k = 0; k < 4; k++)
        sbq.push_back(mk_exp(c0 + 2 + hs[k], {name, "_hseq"}, 9'(hs[k]), vexp, p.len,
                             p.locked, 1'b0, 1'b0, 1'b1, p.chk_len));
    end
    if (p.vat > 0) begin
      sbq.push_back(mk_exp(c0 + p.vat + 4, {name, "_vhold"}, 9'(p.vat + 2), vexp, p.len,
                           p.locked, 1'b0, 1'b0, 1'b1, p.chk_len));
      vpend_m = 1'b1;
    end
    for (int i = 0; i < p.gap; i++) begin
      HSYNC = (i < p.width);
      VSYNC = (i == p.vat);
      tick();
    end
    HSYNC = 1'b0;
    VSYNC = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;

    tbl[0] = mk_vec(341, 1, -1, 1'b0, 9'd0,   1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++)
      tbl[i] = mk_vec(341, 1, -1, 1'b1, 9'd341, 1'b0, 1'b0, 1'b0);
    tbl[4] = mk_vec(341, 1, -1,  1'b1, 9'd341, 1'b1, 1'b0, 1'b0);
    tbl[5] = mk_vec(341, 1, 100, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0);
    tbl[6] = mk_vec(341, 1, -1,  1'b1, 9'd341, 1'b1, 1'b0, 1'b0);
    tbl[7] = mk_vec(340, 1, -1,  1'b1, 9'd341, 1'b1, 1'b0, 1'b0);
`ifdef PPU_HV_SYNC_ODD_SKIP_EN
    tbl[8]  = mk_vec(341, 1, -1, 1'b1, 9'd340, 1'b1, 1'b1, 1'b0);
    tbl[9]  = mk_vec(300, 1, -1, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk_vec(341, 1, -1, 1'b1, 9'd300, 1'b0, 1'b0, 1'b1);
    for (int i = 11; i < 15; i++)
      tbl[i] = mk_vec(341, 1, -1, 1'b1, 9'd341, 1'b0, 1'b0, 1'b0);
`else
    tbl[8]  = mk_vec(341, 1, -1, 1'b1, 9'd340, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mk_vec(300, 1, -1, 1'b1, 9'd341, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk_vec(341, 1, -1, 1'b1, 9'd300, 1'b0, 1'b0, 1'b0);
    for (int i = 11; i < 14; i++)
      tbl[i] = mk_vec(341, 1, -1, 1'b1, 9'd341, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk_vec(341, 1, -1, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0);
`endif
    tbl[15] = mk_vec(341, 1,  -1, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk_vec(341, 1,   0, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0);
    tbl[17] = mk_vec(341, 50, -1, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0);
    tbl[18] = mk_vec(341, 1,  -1, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0);

    RES   = 1'b1;
    HSYNC = 1'b0;
    VSYNC = 1'b0;
    repeat (3) tick();
    sbq.push_back(mk_exp(cyc + 1, "reset", 9'd0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    tick();
    RES = 1'b0;

    for (int i = 0; i < 19; i++)
      pulse(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Locked line with dot sampling, then HSYNC stops and H saturates.
    c0 = cyc;
    pulse(mk_vec(341, 1, -1, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0), 1'b1, "pre_timeout");
    sbq.push_back(mk_exp(c0 + 513, "timeout", 9'd511, vexp, 9'd341, 1'b0, 1'b0, 1'b1,
                         1'b1, 1'b1));
    sbq.push_back(mk_exp(c0 + 514, "timeout_next", 9'd511, vexp, 9'd341, 1'b0, 1'b0, 1'b0,
                         1'b1, 1'b1));
    while (cyc < c0 + 530) tick();

    pulse(mk_vec(341, 1, -1, 1'b1, 9'd511, 1'b0, 1'b0, 1'b0), 1'b0, "relock0_sat");
    for (int i = 1; i < 4; i++)
      pulse(mk_vec(341, 1, -1, 1'b1, 9'd341, 1'b0, 1'b0, 1'b0), 1'b0, $sformatf("relock%0d", i));
    pulse(mk_vec(341, 1, -1, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0), 1'b0, "relock4");

    // Reset while locked at H_out=200.
    pulse(mk_vec(202, 1, -1, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0), 1'b0, "pre_res");
    sbq.push_back(mk_exp(cyc + 1, "res_mid", 9'd0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    RES = 1'b1;
    tick();
    RES     = 1'b0;
    vexp    = 9'd0;
    vpend_m = 1'b0;

    pulse(mk_vec(341, 1, -1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0), 1'b0, "post_res0");
    for (int i = 1; i < 4; i++)
      pulse(mk_vec(341, 1, -1, 1'b1, 9'd341, 1'b0, 1'b0, 1'b0), 1'b0, $sformatf("post_res%0d", i));
    pulse(mk_vec(20, 1, -1, 1'b1, 9'd341, 1'b1, 1'b0, 1'b0), 1'b0, "post_res4");
    repeat (5) tick();

    if (sbq.size() != 0) begin
      n_checks = n_checks + 1;
      n_err    = n_err + 1;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
